kmeans_bitserial_sched: RTL and testbench

KMEANS_BITSERIAL_SCHED -- requirements
Module: kmeans_bitserial_sched

---
 rtl/kmeans_bitserial_sched_pkg.sv | 31 +++
 rtl/kmeans_bitserial_sched_buf.sv | 26 ++
 rtl/kmeans_bitserial_sched.sv | 202 ++++++++++++++++++++
 tb/tb_kmeans_bitserial_sched.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_bitserial_sched_pkg.sv
// Shared sizes, state encoding and beat-count helper for the bit-serial k-means scheduler.
package kmeansTypes;
    localparam int NUM_BANK             = 8;
    localparam int NUM_BANK_LOG2        = 3;
    localparam int MAX_DEPTH_BITS       = 9;
    localparam int MAX_NUM_CLUSTER_BITS = 4;
    localparam int SCHED_BUF_DEPTH      = 256;
    localparam int SCHED_BUF_BITS       = 8;
    localparam int BEAT_BITS            = 16;
    localparam int DIST_BITS            = 48;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_REPLAY = 3'd2,
        S_DRAIN  = 3'd3,
        S_EMIT   = 3'd4
    } sched_state_t;

    // Beats per sample: bit planes times NUM_BANK-wide dimension blocks.
    function automatic logic [BEAT_BITS-1:0] calc_beats(
        input logic [5:0]              nb_m1,
        input logic [MAX_DEPTH_BITS:0] dim_m1
    );
        logic [BEAT_BITS-1:0] planes;
        logic [BEAT_BITS-1:0] blocks;
        planes = BEAT_BITS'(nb_m1) + BEAT_BITS'(1);
        blocks = (BEAT_BITS'(dim_m1) + BEAT_BITS'(1)) >> NUM_BANK_LOG2;
        return planes * blocks;
    endfunction
endpackage

// File: rtl/kmeans_bitserial_sched_buf.sv
// Simple dual-port bit-plane buffer: one write port, one registered read port.
module kmeans_bitplane_buf
    import kmeansTypes::*;
(
    input  logic                      clk,
    input  logic                      i_wr_en,
    input  logic [SCHED_BUF_BITS-1:0] i_wr_addr,
    input  logic [NUM_BANK-1:0]       i_wr_data,
    input  logic                      i_rd_en,
    input  logic [SCHED_BUF_BITS-1:0] i_rd_addr,
    output logic [NUM_BANK-1:0]       o_rd_data
);
    logic [NUM_BANK-1:0] r_mem [SCHED_BUF_DEPTH];
    logic [NUM_BANK-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/kmeans_bitserial_sched.sv
// Streams each sample's bit planes to the MAC once per centroid (live for centroid 0,
// replayed from the buffer for the rest) and keeps a running argmin of the returned distances.
module kmeans_bitserial_sched
    import kmeansTypes::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [5:0]                      numBits_minus_1,
    input  logic [MAX_DEPTH_BITS:0]         data_dim_minus_1,
    input  logic [MAX_NUM_CLUSTER_BITS-1:0] num_cl_minus_1,
    input  logic [31:0]                     num_samples,
    input  logic                            s_bits_valid,
    output logic                            s_bits_ready,
    input  logic [NUM_BANK-1:0]             s_bits,
    output logic                            mac_a_valid,
    output logic [NUM_BANK-1:0]             mac_a,
    output logic [MAX_NUM_CLUSTER_BITS-1:0] mac_cent_idx,
    input  logic signed [DIST_BITS-1:0]     mac_result,
    input  logic                            mac_result_valid,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_NUM_CLUSTER_BITS-1:0] out_cluster,
    output logic signed [DIST_BITS-1:0]     out_dist,
    output logic                            busy,
    output logic                            done,
    output logic [2:0]                      dbg_state
);
    localparam int CL = MAX_NUM_CLUSTER_BITS;

    sched_state_t r_state, w_next;

    logic [BEAT_BITS-1:0]        r_beats, r_beat_cnt;
    logic [CL-1:0]               r_k_m1, r_pass;
    logic [31:0]                 r_num_samples, r_sample_cnt;
    logic [CL:0]                 r_res_cnt;
    logic [CL-1:0]               r_min_idx;
    logic signed [DIST_BITS-1:0] r_min;
    logic                        r_rd_valid;
    logic [CL-1:0]               r_rd_cent;
    logic                        r_mac_valid;
    logic [NUM_BANK-1:0]         r_mac_a;
    logic [CL-1:0]               r_mac_idx;
    logic                        r_done;

    logic                w_load_acc, w_beat_last, w_pass_last, w_res_take;
    logic                w_all_res, w_emit_hs, w_last_sample, w_rd_en, w_start_ok;
    logic [NUM_BANK-1:0] w_rd_data;

    assign w_start_ok    = (r_state == S_IDLE) && start;
    assign w_load_acc    = (r_state == S_LOAD) && s_bits_valid;
    assign w_beat_last   = (r_beat_cnt == r_beats - BEAT_BITS'(1));
    assign w_pass_last   = (r_pass == r_k_m1);
    // A result counts only while fewer than K have arrived for the current sample.
    assign w_res_take    = (r_state != S_IDLE) && mac_result_valid && (r_res_cnt <= {1'b0, r_k_m1});
    assign w_all_res     = (r_res_cnt == ({1'b0, r_k_m1} + (CL+1)'(1)));
    assign w_emit_hs     = (r_state == S_EMIT) && out_ready;
    assign w_last_sample = (r_sample_cnt == r_num_samples - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        s_bits_ready = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        w_rd_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && (num_samples != 32'd0)) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                s_bits_ready = 1'b1;
                if (w_load_acc && w_beat_last) begin
                    w_next = (r_k_m1 == '0) ? S_DRAIN : S_REPLAY;
                end
            end
            S_REPLAY: begin
                w_rd_en = 1'b1;
                if (w_beat_last && w_pass_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_all_res) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = w_last_sample ? S_IDLE : S_LOAD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats       <= '0;
            r_k_m1        <= '0;
            r_num_samples <= '0;
            r_sample_cnt  <= '0;
            r_beat_cnt    <= '0;
            r_pass        <= '0;
        end else begin
            if (w_start_ok) begin
                r_beats       <= calc_beats(numBits_minus_1, data_dim_minus_1);
                r_k_m1        <= num_cl_minus_1;
                r_num_samples <= num_samples;
                r_sample_cnt  <= '0;
                r_beat_cnt    <= '0;
            end else if (w_load_acc || (r_state == S_REPLAY)) begin
                r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + BEAT_BITS'(1);
            end
            if (w_load_acc && w_beat_last) begin
                r_pass <= CL'(1);
            end else if ((r_state == S_REPLAY) && w_beat_last && !w_pass_last) begin
                r_pass <= r_pass + CL'(1);
            end
            if (w_emit_hs) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
        end
    end

    // Live beats go straight to the output register; replayed beats take one extra
    // cycle through the RAM, which yields the single bubble after LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_rd_cent   <= '0;
            r_mac_valid <= 1'b0;
            r_mac_a     <= '0;
            r_mac_idx   <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_rd_cent  <= r_pass;
            if (w_load_acc) begin
                r_mac_valid <= 1'b1;
                r_mac_a     <= s_bits;
                r_mac_idx   <= '0;
            end else if (r_rd_valid) begin
                r_mac_valid <= 1'b1;
                r_mac_a     <= w_rd_data;
                r_mac_idx   <= r_rd_cent;
            end else begin
                r_mac_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_cnt <= '0;
            r_min_idx <= '0;
            r_min     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (w_start_ok && (num_samples == 32'd0)) || (w_emit_hs && w_last_sample);
            if (w_start_ok || w_emit_hs) begin
                r_res_cnt <= '0;
            end else if (w_res_take) begin
                r_res_cnt <= r_res_cnt + (CL+1)'(1);
                if ((r_res_cnt == '0) || (mac_result < r_min)) begin
                    r_min     <= mac_result;
                    r_min_idx <= r_res_cnt[CL-1:0];
                end
            end
        end
    end

    kmeans_bitplane_buf u_buf (
        .clk       (clk),
        .i_wr_en   (w_load_acc),
        .i_wr_addr (r_beat_cnt[SCHED_BUF_BITS-1:0]),
        .i_wr_data (s_bits),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_beat_cnt[SCHED_BUF_BITS-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign mac_a_valid  = r_mac_valid;
    assign mac_a        = r_mac_a;
    assign mac_cent_idx = r_mac_idx;
    assign out_cluster  = r_min_idx;
    assign out_dist     = r_min;
    assign done         = r_done;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_kmeans_bitserial_sched.sv
// Directed bench for the bit-serial k-means scheduler: beat order, replay timing, argmin and job control.
module tb_kmeans_bitserial_sched;
    import kmeansTypes::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [5:0]           numBits_minus_1;
    logic [9:0]           data_dim_minus_1;
    logic [3:0]           num_cl_minus_1;
    logic [31:0]          num_samples;
    logic                 s_bits_valid;
    logic                 s_bits_ready;
    logic [7:0]           s_bits;
    logic                 mac_a_valid;
    logic [7:0]           mac_a;
    logic [3:0]           mac_cent_idx;
    logic signed [47:0]   mac_result;
    logic                 mac_result_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_cluster;
    logic signed [47:0]   out_dist;
    logic                 busy;
    logic                 done;
    logic [2:0]           dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [11:0] exp_q[$];
    logic [11:0] mon_q[$];
    int          mon_cyc[$];
    logic [7:0]  ld_words [0:31];
    int          ld_n;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mac_a_valid === 1'b1) begin
            mon_q.push_back({mac_cent_idx, mac_a});
            mon_cyc.push_back(cyc);
        end
    end

    kmeans_bitserial_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .numBits_minus_1  (numBits_minus_1),
        .data_dim_minus_1 (data_dim_minus_1),
        .num_cl_minus_1   (num_cl_minus_1),
        .num_samples      (num_samples),
        .s_bits_valid     (s_bits_valid),
        .s_bits_ready     (s_bits_ready),
        .s_bits           (s_bits),
        .mac_a_valid      (mac_a_valid),
        .mac_a            (mac_a),
        .mac_cent_idx     (mac_cent_idx),
        .mac_result       (mac_result),
        .mac_result_valid (mac_result_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_cluster      (out_cluster),
        .out_dist         (out_dist),
        .busy             (busy),
        .done             (done),
        .dbg_state        (dbg_state)
    );

    // ---------------- driver tasks (all end #1 after a rising edge) ----------------
    task automatic start_job(input logic [5:0] nb, input logic [9:0] dim,
                             input logic [3:0] k, input logic [31:0] ns);
        @(posedge clk); #1;
        numBits_minus_1  = nb;
        data_dim_minus_1 = dim;
        num_cl_minus_1   = k;
        num_samples      = ns;
        start            = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input bit toggle);
        bit acc;
        int guard;
        for (int i = 0; i < ld_n; i++) begin
            acc   = 1'b0;
            guard = 0;
            s_bits = ld_words[i];
            while (!acc && guard < 50) begin
                if (toggle) begin
                    s_bits_valid = 1'b0;
                    @(posedge clk); #1;
                end
                s_bits_valid = 1'b1;
                @(negedge clk);
                acc = s_bits_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL send_word[%0d]: s_bits_ready stayed 0, required 1 within 50 cycles", i);
            end
        end
        s_bits_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int g;
        g = 0;
        while (mon_q.size() < n && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (mon_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_beats: got %0d mac beats, required %0d", mon_q.size(), n);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_result(input logic signed [47:0] v);
        mac_result       = v;
        mac_result_valid = 1'b1;
        @(posedge clk); #1;
        mac_result_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (out_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_out_valid: out_valid=%b, required 1 within 200 cycles", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mac_a_valid, s_bits_ready, out_valid, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 00000", {mac_a_valid, s_bits_ready, out_valid, busy, done});
        end
        vectors++;
        if ({mac_cent_idx, mac_a, out_cluster} !== 16'h0 || out_dist !== 48'sd0) begin
            miscompares++;
            $display("FAIL reset_data: idx=%0d a=%h cl=%0d dist=%0d, required all 0", mac_cent_idx, mac_a, out_cluster, out_dist);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy=%b state=%0d, required 0/0", busy, dbg_state);
        end
    endtask

    task automatic test_load_replay();
        ld_words[0] = 8'hA5; ld_words[1] = 8'h3C; ld_words[2] = 8'h81; ld_words[3] = 8'h7E;
        ld_words[4] = 8'h00; ld_words[5] = 8'hFF; ld_words[6] = 8'h5A; ld_words[7] = 8'hC3;
        ld_n = 8;
        exp_q.delete(); mon_q.delete(); mon_cyc.delete();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 8; i++)
                exp_q.push_back({4'(c), ld_words[i]});
        start_job(6'd3, 10'd15, 4'd2, 32'd1);
        vectors++;
        if (busy !== 1'b1 || s_bits_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_to_load: busy=%b ready=%b, required 1/1", busy, s_bits_ready);
        end
        send_words(1'b0);
        wait_beats(24);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (mon_q.size() != 24) begin
            miscompares++;
            $display("FAIL beat_count: got %0d beats, required 24", mon_q.size());
        end
        for (int i = 0; i < 24 && i < mon_q.size(); i++) begin
            vectors++;
            if (mon_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL beat[%0d]: got cent=%0d a=%h, required cent=%0d a=%h",
                         i, mon_q[i][11:8], mon_q[i][7:0], exp_q[i][11:8], exp_q[i][7:0]);
            end
        end
        if (mon_cyc.size() >= 24) begin
            vectors++;
            if (mon_cyc[7] - mon_cyc[0] != 7 || mon_cyc[8] - mon_cyc[7] != 2 || mon_cyc[23] - mon_cyc[8] != 15) begin
                miscompares++;
                $display("FAIL replay_timing: load span %0d gap %0d replay span %0d, required 7/2/15",
                         mon_cyc[7] - mon_cyc[0], mon_cyc[8] - mon_cyc[7], mon_cyc[23] - mon_cyc[8]);
            end
        end
        vectors++;
        if (s_bits_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_flags: ready=%b busy=%b out_valid=%b, required 0/1/0", s_bits_ready, busy, out_valid);
        end
    endtask

    task automatic test_argmin();
        logic signed [47:0] exp_d;
        exp_d = -48'sd5;
        send_result(48'sd100);
        send_result(-48'sd5);
        send_result(-48'sd5);
        send_result(-48'sd1000);
        wait_out_valid();
        vectors++;
        if (out_cluster !== 4'd1 || out_dist !== exp_d) begin
            miscompares++;
            $display("FAIL argmin_tie: got cluster=%0d dist=%0d, required 1/-5", out_cluster, out_dist);
        end
    endtask

    task automatic test_emit_stall();
        logic signed [47:0] exp_d;
        int n0;
        exp_d = -48'sd5;
        n0 = mon_q.size();
        out_ready = 1'b0;
        s_bits_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_cluster !== 4'd1 || out_dist !== exp_d ||
                s_bits_ready !== 1'b0 || mac_a_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL emit_stall[%0d]: valid=%b cl=%0d dist=%0d ready=%b mac_v=%b, required 1/1/-5/0/0",
                         i, out_valid, out_cluster, out_dist, s_bits_ready, mac_a_valid);
            end
        end
        s_bits_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (mon_q.size() != n0) begin
            miscompares++;
            $display("FAIL emit_no_beats: got %0d new beats, required 0", mon_q.size() - n0);
        end
        handshake();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL last_done: done=%b busy=%b out_valid=%b, required 1/0/0", done, busy, out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_zero_samples();
        start_job(6'd0, 10'd7, 4'd0, 32'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || s_bits_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: done=%b busy=%b ready=%b, required 1/0/0", done, busy, s_bits_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_midjob_reset();
        ld_words[0] = 8'h01; ld_words[1] = 8'h23; ld_words[2] = 8'h45; ld_words[3] = 8'h67;
        ld_words[4] = 8'h89; ld_words[5] = 8'hAB; ld_words[6] = 8'hCD; ld_words[7] = 8'hEF;
        ld_n = 8;
        mon_q.delete(); mon_cyc.delete();
        start_job(6'd3, 10'd15, 4'd2, 32'd1);
        send_words(1'b0);
        wait_beats(12);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mac_a_valid, s_bits_ready, out_valid, busy, done} !== 5'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL midjob_reset_flags: got %b state=%0d, required 00000 state=0",
                     {mac_a_valid, s_bits_ready, out_valid, busy, done}, dbg_state);
        end
        vectors++;
        if ({mac_cent_idx, mac_a, out_cluster} !== 16'h0 || out_dist !== 48'sd0) begin
            miscompares++;
            $display("FAIL midjob_reset_data: idx=%0d a=%h cl=%0d dist=%0d, required all 0",
                     mac_cent_idx, mac_a, out_cluster, out_dist);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_q.delete(); mon_cyc.delete(); exp_q.delete();
        ld_words[0] = 8'h11; ld_words[1] = 8'h22;
        ld_n = 2;
        exp_q.push_back({4'd0, 8'h11});
        exp_q.push_back({4'd0, 8'h22});
        start_job(6'd1, 10'd7, 4'd0, 32'd1);
        send_words(1'b0);
        wait_beats(2);
        send_result(48'sd42);
        wait_out_valid();
        vectors++;
        if (mon_q.size() != 2) begin
            miscompares++;
            $display("FAIL rerun_beats: got %0d beats, required 2", mon_q.size());
        end
        for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
            vectors++;
            if (mon_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rerun_beat[%0d]: got %h, required %h", i, mon_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (out_cluster !== 4'd0 || out_dist !== 48'sd42) begin
            miscompares++;
            $display("FAIL rerun_result: cl=%0d dist=%0d, required 0/42", out_cluster, out_dist);
        end
        handshake();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rerun_done: done=%b busy=%b, required 1/0", done, busy);
        end
    endtask

    task automatic test_toggle_valid();
        logic signed [47:0] dists [0:1];
        dists[0] = 48'sd12345;
        dists[1] = -48'sd7;
        start_job(6'd1, 10'd15, 4'd0, 32'd2);
        for (int s = 0; s < 2; s++) begin
            mon_q.delete(); mon_cyc.delete(); exp_q.delete();
            ld_n = 4;
            for (int i = 0; i < 4; i++) begin
                ld_words[i] = 8'(8'h01 << (4 * s + i));
                exp_q.push_back({4'd0, ld_words[i]});
            end
            send_words(1'b1);
            wait_beats(4);
            for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
                vectors++;
                if (mon_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL toggle_beat[%0d][%0d]: got %h, required %h", s, i, mon_q[i], exp_q[i]);
                end
            end
            if (mon_cyc.size() >= 4) begin
                vectors++;
                if (mon_cyc[1] - mon_cyc[0] != 2 || mon_cyc[3] - mon_cyc[2] != 2) begin
                    miscompares++;
                    $display("FAIL toggle_gaps[%0d]: gaps %0d/%0d, required 2/2",
                             s, mon_cyc[1] - mon_cyc[0], mon_cyc[3] - mon_cyc[2]);
                end
            end
            send_result(dists[s]);
            wait_out_valid();
            vectors++;
            if (out_cluster !== 4'd0 || out_dist !== dists[s]) begin
                miscompares++;
                $display("FAIL toggle_result[%0d]: cl=%0d dist=%0d, required 0/%0d", s, out_cluster, out_dist, dists[s]);
            end
            handshake();
            vectors++;
            if (s == 0 && (done !== 1'b0 || busy !== 1'b1 || s_bits_ready !== 1'b1)) begin
                miscompares++;
                $display("FAIL toggle_next_load: done=%b busy=%b ready=%b, required 0/1/1", done, busy, s_bits_ready);
            end else if (s == 1 && (done !== 1'b1 || busy !== 1'b0)) begin
                miscompares++;
                $display("FAIL toggle_final_done: done=%b busy=%b, required 1/0", done, busy);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        numBits_minus_1  = '0;
        data_dim_minus_1 = '0;
        num_cl_minus_1   = '0;
        num_samples      = '0;
        s_bits_valid     = 1'b0;
        s_bits           = '0;
        mac_result       = '0;
        mac_result_valid = 1'b0;
        out_ready        = 1'b0;
        ld_n             = 0;

        test_reset();
        test_load_replay();
        test_argmin();
        test_emit_stall();
        test_zero_samples();
        test_midjob_reset();
        test_toggle_valid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
